// File: rtl/penalty_tracker_pkg.sv
// Shared game definitions for the penalty tracker and the marker draw stage.
// Holds the state encoding, the default penalty limit and small counter helpers.
package penalty_tracker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COOLDOWN  = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    localparam int MAX_PENALTY_DEFAULT = 3;

    // Marker count shown to the draw stage; the newest marker hides while blinking off.
    function automatic logic [3:0] disp_count(input logic [3:0] num, input logic blink_off);
        logic [3:0] result;
        if (blink_off && (num != 4'd0)) begin
            result = num - 4'd1;
        end else begin
            result = num;
        end
        return result;
    endfunction

    // Width of a counter that must hold 0 .. frames-1, never narrower than one bit.
    function automatic int counter_width(input int frames);
        int w;
        if (frames > 1) begin
            w = $clog2(frames);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/penalty_tracker_checker.sv
// Structural invariants of the penalty tracker outputs, kept apart from the design logic.
module penalty_tracker_checker #(
    parameter int MAX_PENALTY = 3
) (
    input logic       clk,
    input logic       reset,
    input logic [3:0] penalty_num,
    input logic [3:0] penalty_disp,
    input logic       cooldown,
    input logic       game_over
);

    localparam logic [3:0] MAX_NUM = 4'(MAX_PENALTY);

    a_num_range: assert property (@(posedge clk) disable iff (reset)
        penalty_num <= MAX_NUM);

    a_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(cooldown && game_over));

    a_game_over_at_limit: assert property (@(posedge clk) disable iff (reset)
        game_over == (penalty_num == MAX_NUM));

    a_cooldown_nonzero: assert property (@(posedge clk) disable iff (reset)
        cooldown |-> (penalty_num != 4'd0));

    a_disp_relation: assert property (@(posedge clk) disable iff (reset)
        (penalty_disp == penalty_num) ||
        (cooldown && (penalty_disp == penalty_num - 4'd1)));

endmodule

// File: rtl/rise_detect.sv
// Registered 1-bit rising-edge detector; the pulse appears one clock after the input rises.
// A level held high produces exactly one pulse.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Delay the input once and flag a low-to-high transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q  <= 1'b0;
            rise <= 1'b0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
        end
    end

endmodule

// File: rtl/penalty_tracker.sv
// Counts accepted strikes, enforces a frame-based cooldown with a blinking newest marker,
// and flags game over at the penalty limit. All outputs are registered.
module penalty_tracker
    import penalty_tracker_pkg::*;
#(
    parameter int MAX_PENALTY     = MAX_PENALTY_DEFAULT,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int BLINK_FRAMES    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       strike,
    input  logic       clear_round,
    output logic [3:0] penalty_num,
    output logic [3:0] penalty_disp,
    output logic       cooldown,
    output logic       game_over
);

    localparam int CW = counter_width(COOLDOWN_FRAMES);
    localparam int BW = counter_width(BLINK_FRAMES);

    localparam logic [3:0]    MAX_NUM     = 4'(MAX_PENALTY);
    localparam logic [CW-1:0] FRAME_LAST  = CW'(COOLDOWN_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_FRAMES - 1);

    state_t        state_r;
    logic [CW-1:0] frame_cnt_r;
    logic [BW-1:0] blink_cnt_r;
    logic          blink_off_r;
    logic          strike_rise_s;
    logic [3:0]    next_num_s;

    rise_detect u_strike_rise (
        .clk   (clk),
        .reset (reset),
        .d     (strike),
        .rise  (strike_rise_s)
    );

    // Saturating increment of the accepted count.
    always_comb begin
        next_num_s = penalty_num;
        if (penalty_num < MAX_NUM) begin
            next_num_s = penalty_num + 4'd1;
        end else begin
            next_num_s = penalty_num;
        end
    end

    // Round state machine with registered outputs; clear_round overrides everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            frame_cnt_r  <= '0;
            blink_cnt_r  <= '0;
            blink_off_r  <= 1'b0;
            penalty_num  <= 4'd0;
            penalty_disp <= 4'd0;
            cooldown     <= 1'b0;
            game_over    <= 1'b0;
        end else if (clear_round) begin
            state_r      <= ST_IDLE;
            frame_cnt_r  <= '0;
            blink_cnt_r  <= '0;
            blink_off_r  <= 1'b0;
            penalty_num  <= 4'd0;
            penalty_disp <= 4'd0;
            cooldown     <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A coincident frame_tick is deliberately not counted here.
                    if (strike_rise_s) begin
                        penalty_num  <= next_num_s;
                        penalty_disp <= next_num_s;
                        frame_cnt_r  <= '0;
                        blink_cnt_r  <= '0;
                        blink_off_r  <= 1'b0;
                        if (next_num_s == MAX_NUM) begin
                            state_r   <= ST_GAME_OVER;
                            game_over <= 1'b1;
                            cooldown  <= 1'b0;
                        end else begin
                            state_r   <= ST_COOLDOWN;
                            cooldown  <= 1'b1;
                            game_over <= 1'b0;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (frame_tick) begin
                        if (frame_cnt_r == FRAME_LAST) begin
                            state_r      <= ST_IDLE;
                            frame_cnt_r  <= '0;
                            blink_cnt_r  <= '0;
                            blink_off_r  <= 1'b0;
                            penalty_disp <= penalty_num;
                            cooldown     <= 1'b0;
                        end else begin
                            frame_cnt_r <= frame_cnt_r + 1'b1;
                            if (blink_cnt_r == BLINK_LAST) begin
                                blink_cnt_r  <= '0;
                                blink_off_r  <= ~blink_off_r;
                                penalty_disp <= disp_count(penalty_num, ~blink_off_r);
                            end else begin
                                blink_cnt_r <= blink_cnt_r + 1'b1;
                            end
                        end
                    end
                end
                ST_GAME_OVER: begin
                    state_r <= ST_GAME_OVER;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    frame_cnt_r  <= '0;
                    blink_cnt_r  <= '0;
                    blink_off_r  <= 1'b0;
                    penalty_disp <= penalty_num;
                    cooldown     <= 1'b0;
                    game_over    <= 1'b0;
                end
            endcase
        end
    end

    penalty_tracker_checker #(
        .MAX_PENALTY (MAX_PENALTY)
    ) u_checker (
        .clk          (clk),
        .reset        (reset),
        .penalty_num  (penalty_num),
        .penalty_disp (penalty_disp),
        .cooldown     (cooldown),
        .game_over    (game_over)
    );

endmodule

// File: tb/tb_penalty_tracker.sv
// Directed bench for penalty_tracker with hand-computed expectations (defaults 3/30/5).
module tb_penalty_tracker;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       strike;
    logic       clear_round;
    logic [3:0] penalty_num;
    logic [3:0] penalty_disp;
    logic       cooldown;
    logic       game_over;

    int vectors;
    int miscompares;

    penalty_tracker dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .strike       (strike),
        .clear_round  (clear_round),
        .penalty_num  (penalty_num),
        .penalty_disp (penalty_disp),
        .cooldown     (cooldown),
        .game_over    (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] num, input logic [3:0] disp,
                           input logic cd, input logic go);
        chk({tag, ".num"},  penalty_num,  num);
        chk({tag, ".disp"}, penalty_disp, disp);
        chk({tag, ".cd"},   {3'd0, cooldown},  {3'd0, cd});
        chk({tag, ".go"},   {3'd0, game_over}, {3'd0, go});
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        clk1();
        frame_tick = 1'b0;
        clk1();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse_tick();
    endtask

    task automatic do_strike();
        strike = 1'b1;
        clk1();
        clk1();
        strike = 1'b0;
        clk1();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        frame_tick  = 1'b0;
        strike      = 1'b0;
        clear_round = 1'b0;
        clk1();
        clk1();
        chk_all("reset", 4'd0, 4'd0, 1'b0, 1'b0);
        reset = 1'b0;
        clk1();

        // Held strike counts once; 2-clock latency; no ticks so no blinking.
        strike = 1'b1;
        clk1();
        chk("latency1.num", penalty_num, 4'd0);
        clk1();
        chk_all("first_strike", 4'd1, 4'd1, 1'b1, 1'b0);
        for (int i = 0; i < 48; i++) begin
            clk1();
            chk("held.disp", penalty_disp, 4'd1);
        end
        chk_all("held_end", 4'd1, 4'd1, 1'b1, 1'b0);
        strike = 1'b0;
        clk1();

        // Blink: off after tick 5, on after tick 10.
        ticks(4);
        chk("tick4.disp", penalty_disp, 4'd1);
        ticks(1);
        chk_all("tick5", 4'd1, 4'd0, 1'b1, 1'b0);
        ticks(5);
        chk("tick10.disp", penalty_disp, 4'd1);
        do_strike();
        chk_all("cd_strike_ignored", 4'd1, 4'd1, 1'b1, 1'b0);
        ticks(19);
        chk_all("tick29", 4'd1, 4'd0, 1'b1, 1'b0);
        ticks(1);
        chk_all("tick30", 4'd1, 4'd1, 1'b0, 1'b0);

        // Second and third penalties, then game over.
        do_strike();
        chk_all("second", 4'd2, 4'd2, 1'b1, 1'b0);
        ticks(5);
        chk("second_blink.disp", penalty_disp, 4'd1);
        ticks(25);
        chk_all("second_end", 4'd2, 4'd2, 1'b0, 1'b0);
        do_strike();
        chk_all("third", 4'd3, 4'd3, 1'b0, 1'b1);
        do_strike();
        ticks(3);
        chk_all("fourth_ignored", 4'd3, 4'd3, 1'b0, 1'b1);

        // clear_round coincident with the registered strike rise.
        strike = 1'b1;
        clk1();
        clear_round = 1'b1;
        clk1();
        clear_round = 1'b0;
        chk_all("clear", 4'd0, 4'd0, 1'b0, 1'b0);
        strike = 1'b0;
        clk1();
        clk1();
        chk("clear_discard.num", penalty_num, 4'd0);
        do_strike();
        chk_all("after_clear", 4'd1, 4'd1, 1'b1, 1'b0);

        // Asynchronous reset mid-cooldown with blink off.
        ticks(30);
        do_strike();
        ticks(5);
        chk_all("pre_reset", 4'd2, 4'd1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 4'd0, 4'd0, 1'b0, 1'b0);
        clk1();
        reset = 1'b0;
        clk1();
        ticks(6);
        chk_all("post_reset", 4'd0, 4'd0, 1'b0, 1'b0);

        // Strike and frame_tick in the same cycle: tick not counted.
        strike = 1'b1;
        clk1();
        frame_tick = 1'b1;
        clk1();
        frame_tick = 1'b0;
        strike     = 1'b0;
        chk_all("same_cycle", 4'd1, 4'd1, 1'b1, 1'b0);
        clk1();
        ticks(5);
        chk("same_cycle_tick5.disp", penalty_disp, 4'd0);
        ticks(24);
        chk_all("same_cycle_tick29", 4'd1, 4'd0, 1'b1, 1'b0);
        ticks(1);
        chk_all("same_cycle_tick30", 4'd1, 4'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
